// File: rtl/game_pkg.sv
// Shared definitions for the memory/sequence game: FSM state codes, setup
// register field positions and the default player-timeout multiplier.
package game_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    SHOW  = 3'd3,
    PLAY  = 3'd4,
    WIN   = 3'd5,
    LOSE  = 3'd6
  } state_t;

  localparam int LEVEL_HI  = 7;
  localparam int LEVEL_LO  = 6;
  localparam int MAP_HI    = 5;
  localparam int MAP_LO    = 4;
  localparam int ROUNDS_HI = 3;
  localparam int ROUNDS_LO = 0;

  localparam int TO_MULT_DEF = 8;

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is
// zero, so a caller that reloads on done sees a one-cycle pulse.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/game_ctrl.sv
// Main sequencing FSM of the memory game: setup capture, sequence display,
// press checking, round advance and win/lose handling.
module game_ctrl
  import game_pkg::*;
#(
  parameter int BASE_TICKS = 50_000_000,
  parameter int TO_MULT    = TO_MULT_DEF
) (
  input  logic       clk,
  input  logic       R,
  input  logic       enter,
  input  logic [7:0] setup,
  input  logic       btn_valid,
  input  logic       btn_match,
  output logic       E_setup,
  output logic       show,
  output logic [3:0] seq_idx,
  output logic [3:0] round,
  output logic       win,
  output logic       lose,
  output logic [2:0] state
);

  localparam int PW  = $clog2(BASE_TICKS);
  localparam int TW  = PW + $clog2(TO_MULT);
  localparam int TW1 = TW + 1;

  state_t        state_q, state_d;
  logic [3:0]    seq_q, seq_d;
  logic [3:0]    round_q, round_d;
  logic          show_on_q, show_on_d;
  logic [PW-1:0] pm1_q, pm1_d;
  logic [3:0]    rmax_q, rmax_d;
  logic [2:0]    sync_q;
  logic          ent_p;
  logic          e_setup;

  logic [1:0]    level;
  logic [3:0]    rounds;
  logic [PW-1:0] pm1_load, pm1_cur;
  logic [TW1-1:0] to_full;
  logic [TW-1:0] to_load;
  logic          p_done, t_done, last_round;
  logic          unused_map;

  assign level      = setup[LEVEL_HI:LEVEL_LO];
  assign rounds     = setup[ROUNDS_HI:ROUNDS_LO];
  assign unused_map = ^setup[MAP_HI:MAP_LO];

  // Timers hold period-1 so a full level-0 period fits in clog2(BASE_TICKS) bits.
  assign pm1_load = PW'((BASE_TICKS >> level) - 1);
  assign pm1_cur  = (state_q == LOAD) ? pm1_load : pm1_q;
  assign to_full  = (TW1'(pm1_cur) + TW1'(1)) * TW1'(TO_MULT) - TW1'(1);
  assign to_load  = to_full[TW-1:0];

  assign last_round = ({1'b0, round_q} + 5'd1) == {1'b0, rmax_q};

  // Both timers are held loaded outside the state that consumes them.
  tick_timer #(.W(PW)) u_period (
    .clk      (clk),
    .rst_n    (R),
    .load     ((state_q != SHOW) | p_done),
    .load_val (pm1_cur),
    .done     (p_done)
  );

  tick_timer #(.W(TW)) u_timeout (
    .clk      (clk),
    .rst_n    (R),
    .load     ((state_q != PLAY) | btn_valid),
    .load_val (to_load),
    .done     (t_done)
  );

  // Two synchronizer flops, a history flop, and a registered edge pulse.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      sync_q <= '0;
      ent_p  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], enter};
      ent_p  <= sync_q[1] & ~sync_q[2];
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q   <= INIT;
      seq_q     <= '0;
      round_q   <= '0;
      show_on_q <= 1'b0;
      pm1_q     <= '0;
      rmax_q    <= '0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      round_q   <= round_d;
      show_on_q <= show_on_d;
      pm1_q     <= pm1_d;
      rmax_q    <= rmax_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    round_d   = round_q;
    show_on_d = show_on_q;
    pm1_d     = pm1_q;
    rmax_d    = rmax_q;
    e_setup   = 1'b0;

    case (state_q)
      INIT: begin
        if (ent_p) state_d = SETUP;
      end
      SETUP: begin
        if (ent_p) begin
          e_setup = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        pm1_d     = pm1_load;
        rmax_d    = (rounds == 4'd0) ? 4'd1 : rounds;
        seq_d     = '0;
        round_d   = '0;
        show_on_d = 1'b1;
        state_d   = SHOW;
      end
      SHOW: begin
        if (p_done) begin
          if (show_on_q) begin
            show_on_d = 1'b0;
          end else if (seq_q == round_q) begin
            seq_d   = '0;
            state_d = PLAY;
          end else begin
            seq_d     = seq_q + 4'd1;
            show_on_d = 1'b1;
          end
        end
      end
      PLAY: begin
        if (btn_valid) begin
          if (!btn_match) begin
            state_d = LOSE;
          end else if (seq_q != round_q) begin
            seq_d = seq_q + 4'd1;
          end else if (last_round) begin
            state_d = WIN;
          end else begin
            round_d   = round_q + 4'd1;
            seq_d     = '0;
            show_on_d = 1'b1;
            state_d   = SHOW;
          end
        end else if (t_done) begin
          state_d = LOSE;
        end
      end
      WIN, LOSE: begin
        if (ent_p) begin
          seq_d   = '0;
          round_d = '0;
          state_d = SETUP;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign E_setup = e_setup;
  assign show    = (state_q == SHOW) & show_on_q;
  assign seq_idx = seq_q;
  assign round   = round_q;
  assign win     = (state_q == WIN);
  assign lose    = (state_q == LOSE);
  assign state   = state_q;

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Main sequencing FSM of the memory/sequence game. It drives the setup register's enable so that the player's switch choices are captured. It then uses the captured level, map and round count to run the game loop: show the sequence, collect player presses, check them, advance the round, and declare a win or a loss. It sits between the switch/button front-end, the setup register, the sequence ROM (addressed by `seq_idx`, map bits taken by the datapath directly from `setup[5:4]`) and the display logic.

## Interface
- `BASE_TICKS`, 50_000_000, element display period at level 0 in clk cycles; must be ≥ 8.
- `TO_MULT`, 8, player timeout expressed in display periods.
- `clk`  in  1  system clock; all state changes on rising edge.
- `R`  in  1  reset, asynchronous, active-low.
- `enter`  in  1  raw enter switch (`sw[0]`), asynchronous level.
- `setup`  in  8  setup register output: [7:6] level, [5:4] map, [3:0] rounds.
- `btn_valid`  in  1  one-cycle pulse per player press.
- `btn_match`  in  1  press equals ROM element at `seq_idx`; qualified by `btn_valid`.
- `E_setup`  out  1  setup register enable, one-cycle pulse.
- `show`  out  1  display element at `seq_idx`.
- `seq_idx`  out  4  sequence ROM address.
- `round`  out  4  current round minus 1 (0..15).
- `win`  out  1  held high in WIN.
- `lose`  out  1  held high in LOSE.
- `state`  out  3  current state code, for 7-segment status.

## Operation
- Reset (R=0, async): state=INIT (0). All outputs 0, all counters 0.
- `enter` passes through a 2-flop synchronizer and then a rising-edge detector, producing `ent_p`. Each switch edge yields exactly one `ent_p`.
- INIT (0): on `ent_p` → SETUP.
- SETUP (1): on `ent_p`, `E_setup`=1 for that one cycle → LOAD.
- LOAD (2): one cycle; `setup` is now valid. Latch the following, then → SHOW with `seq_idx`=0 and `round`=0:
  - `period = BASE_TICKS >> level`.
  - `rmax = rounds`; the value 0 is treated as 1.
- SHOW (3): for each element `k` = 0..`round`:
  - `show`=1 for `period` cycles, then `show`=0 for `period` cycles.
  - After the gap of element `k`, `seq_idx` increments.
  - After the gap of element `round`: `seq_idx`=0 → PLAY.
- PLAY (4): the timeout counter loads `TO_MULT*period` on entry and on every `btn_valid`.
  - `btn_valid & !btn_match` → LOSE.
  - `btn_valid & btn_match` with `seq_idx` < `round` → `seq_idx`+1.
  - `btn_valid & btn_match` with `seq_idx` == `round`:
    - if `round+1 == rmax` → WIN;
    - else `round`+1, `seq_idx`=0 → SHOW.
  - Timeout counter reaching 0 with no press → LOSE.
- WIN (5) / LOSE (6): `win`/`lose` held high. `ent_p` clears `win`, `lose`, `round` and `seq_idx` → SETUP (new game without reset).
- `btn_valid` is ignored outside PLAY.
- `ent_p` is ignored in LOAD, SHOW and PLAY.
- Arithmetic:
  - period counter width is clog2(`BASE_TICKS`).
  - timeout counter width is clog2(`BASE_TICKS`)+clog2(`TO_MULT`).
  - counters never wrap: `round` ≤ 15 and `seq_idx` ≤ `round` by construction.

## Timing
- `ent_p` fires on the 3rd rising clk edge after `enter` rises. The state changes on the following edge.
- `E_setup` is high in the cycle SETUP→LOAD is decided. `setup` is sampled in LOAD, one cycle later.
- First `show`=1 is the cycle after LOAD.
- A full SHOW phase lasts exactly `2*period*(round+1)` cycles.
- Press decisions are registered: outputs and state update on the edge after the `btn_valid` cycle. `seq_idx` is stable for at least 1 cycle before any press can be accepted.
- Timeout LOSE occurs exactly `TO_MULT*period` cycles after PLAY entry or after the last press.
- R asserted mid-game returns to INIT asynchronously. It has no effect on the setup register; that register has its own reset.

## Structure
- `game_pkg` holds:
  - state codes INIT..LOSE (3-bit);
  - `setup` field positions (LEVEL [7:6], MAP [5:4], ROUNDS [3:0]);
  - default `TO_MULT`.
- Sub-module `tick_timer`: loadable down-counter with a `done` pulse at 0. It is instantiated twice, once for the period and once for the timeout.

## Test plan
- Reset with `BASE_TICKS`=16: all outputs 0, `state`=0. Two `enter` pulses → one `E_setup` pulse, `state` reaches 3.
- `setup`=8'b01_00_0011 (level 1, period 8, 3 rounds): round 0 → `show` high 8 cycles, low 8, then PLAY; matched presses through the rounds reach WIN. `round` sequence 0,1,2; `win`=1.
- Same setup, round 1: correct press at `seq_idx` 0, wrong press at 1 → LOSE next cycle, `lose`=1, `win`=0.
- Level 3 (period 2), no presses in PLAY → LOSE exactly 16 cycles after PLAY entry. A press at cycle 15 restarts the count instead.
- `rounds`=0 → one round only; a single correct press gives WIN.
- R low during SHOW → immediate INIT with `show`=0. From WIN, `enter` → SETUP with `win`=0 and `round`=0.
